// File: rtl/bfp_unpack.sv
// Block-floating-point decoder: frames of mantissas sharing one exponent
// are rebuilt as saturated mantissa*2^exp in a wider fixed-point format.
module bfp_unpack #(
    parameter int DIN_WIDTH  = 8,
    parameter int DIN_POINT  = 7,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_POINT = 7,
    parameter int EXP_WIDTH  = 4,
    parameter int FRAME_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [EXP_WIDTH-1:0]  exp_in,
    input  logic                  exp_valid,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  dout_sat,
    output logic                  frame_err
);

    localparam int PSH   = DOUT_POINT - DIN_POINT;
    localparam int WW    = DOUT_WIDTH + (1 << EXP_WIDTH) - 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     count, count_nxt, cnt_base;
    logic [EXP_WIDTH-1:0] exp_q, exp_nxt, exp_use;
    logic                 accept, is_last, err_nxt;

    logic                         s1_valid, s1_last;
    logic [EXP_WIDTH-1:0]         s1_exp;
    logic signed [DOUT_WIDTH-1:0] s1_data;

    logic signed [DOUT_WIDTH-1:0] aligned;
    logic signed [WW-1:0]         wide;
    logic [WW-DOUT_WIDTH:0]       top;
    logic                         ovf;
    logic [DOUT_WIDTH-1:0]        sat_val;

    // Frame tracking: exponent latch, sample count, error detection
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        exp_nxt   = exp_q;
        exp_use   = exp_q;
        cnt_base  = count;
        is_last   = 1'b0;
        if (exp_valid) begin
            exp_nxt   = exp_in;
            exp_use   = exp_in;
            cnt_base  = '0;
            count_nxt = '0;
            state_nxt = RUN;
        end
        accept  = din_valid && (exp_valid || state == RUN);
        err_nxt = (state == IDLE && din_valid && !exp_valid)
                || (state == RUN && exp_valid);
        if (accept) begin
            is_last = (cnt_base == LAST_CNT);
            if (is_last) begin
                count_nxt = '0;
                state_nxt = IDLE;
            end else begin
                count_nxt = cnt_base + 1'b1;
            end
        end
    end

    // Frame state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            exp_q <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            exp_q <= exp_nxt;
        end
    end

    assign aligned = DOUT_WIDTH'($signed(din)) <<< PSH;

    // Stage 1: register aligned mantissa with its frame exponent and last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_exp    <= '0;
            s1_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            s1_valid  <= accept;
            s1_last   <= is_last;
            frame_err <= err_nxt;
            if (accept) begin
                s1_exp  <= exp_use;
                s1_data <= aligned;
            end
        end
    end

    assign wide    = WW'(s1_data) <<< s1_exp;
    assign top     = wide[WW-1:DOUT_WIDTH-1];
    assign ovf     = !((&top) || !(|top));
    assign sat_val = wide[WW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                : {1'b0, {(DOUT_WIDTH-1){1'b1}}};

    // Stage 2: apply exponent shift and saturate to output width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_sat   <= 1'b0;
        end else begin
            dout_valid <= s1_valid;
            dout_last  <= s1_valid && s1_last;
            dout_sat   <= s1_valid && ovf;
            if (s1_valid) begin
                dout <= ovf ? sat_val : wide[DOUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bfp_unpack.sv
// Directed bench for bfp_unpack: arithmetic table plus framing,
// error, exponent-hold and reset sequences.
module tb_bfp_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  exp_in = '0;
    logic        exp_valid = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic [15:0] dout;
    logic        dout_valid, dout_last, dout_sat, frame_err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        s;
    } ob_t;

    typedef struct {
        logic [3:0]  e;
        logic [7:0]  m;
        logic [15:0] d;
        logic        s;
    } vec_t;

    ob_t outq[$];
    int  errs = 0;

    bfp_unpack dut (
        .clk(clk), .rst_n(rst_n),
        .exp_in(exp_in), .exp_valid(exp_valid),
        .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid),
        .dout_last(dout_last), .dout_sat(dout_sat),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (dout_valid) outq.push_back('{dout, dout_last, dout_sat});
        if (frame_err) errs++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, req);
        end
    endtask

    task automatic drive(input logic ev, input logic [3:0] e,
                         input logic dv, input logic [7:0] d);
        exp_valid = ev;
        exp_in    = e;
        din_valid = dv;
        din       = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        din_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [15:0] model(input int e, input logic [7:0] m);
        longint v;
        logic [63:0] r;
        v = longint'($signed(m)) * (longint'(1) << e);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        r = 64'(v);
        return r[15:0];
    endfunction

    vec_t vt[10];
    int   qb, eb, n;
    logic [15:0] ed;
    logic        el;

    initial begin
        vt[0] = '{4'd3,  8'h40, 16'h0200, 1'b0};
        vt[1] = '{4'd9,  8'h7F, 16'h7FFF, 1'b1};
        vt[2] = '{4'd9,  8'h80, 16'h8000, 1'b1};
        vt[3] = '{4'd8,  8'h80, 16'h8000, 1'b0};
        vt[4] = '{4'd8,  8'h7F, 16'h7F00, 1'b0};
        vt[5] = '{4'd0,  8'h81, 16'hFF81, 1'b0};
        vt[6] = '{4'd15, 8'h01, 16'h7FFF, 1'b1};
        vt[7] = '{4'd15, 8'hFF, 16'h8000, 1'b0};
        vt[8] = '{4'd7,  8'h01, 16'h0080, 1'b0};
        vt[9] = '{4'd0,  8'h00, 16'h0000, 1'b0};

        do_reset();
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_flags", {28'd0, dout_valid, dout_last, dout_sat, frame_err},
            32'h0);

        // Arithmetic table: one sample per frame, 2-cycle latency
        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(1'b1, vt[i].e, 1'b1, vt[i].m);
            chk($sformatf("v%0d_early", i), 32'(dout_valid), 32'd0);
            chk($sformatf("v%0d_err", i), 32'(frame_err), 32'd0);
            idle(1);
            chk($sformatf("v%0d_valid", i), 32'(dout_valid), 32'd1);
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vt[i].d));
            chk($sformatf("v%0d_sat", i), 32'(dout_sat), 32'(vt[i].s));
            chk($sformatf("v%0d_last", i), 32'(dout_last), 32'd0);
        end

        // Two back-to-back frames, second starts with exp+din together
        do_reset();
        qb = outq.size(); eb = errs;
        drive(1'b1, 4'd1, 1'b0, 8'd0);
        for (int i = 0; i < 64; i++) drive(1'b0, 4'd0, 1'b1, 8'(i));
        drive(1'b1, 4'd2, 1'b1, 8'd5);
        for (int i = 1; i < 64; i++) drive(1'b0, 4'd0, 1'b1, 8'd1);
        idle(4);
        n = outq.size() - qb;
        chk("frm_count", 32'(n), 32'd128);
        chk("frm_err", 32'(errs - eb), 32'd0);
        for (int k = 0; k < n && k < 128; k++) begin
            if (k < 64) begin
                ed = model(1, 8'(k)); el = (k == 63);
            end else if (k == 64) begin
                ed = model(2, 8'd5); el = 1'b0;
            end else begin
                ed = model(2, 8'd1); el = (k == 127);
            end
            chk($sformatf("frm_d%0d", k), 32'(outq[qb+k].d), 32'(ed));
            chk($sformatf("frm_l%0d", k), 32'(outq[qb+k].l), 32'(el));
        end

        // Sample in IDLE without exponent is dropped with one error pulse
        do_reset();
        qb = outq.size(); eb = errs;
        drive(1'b0, 4'd0, 1'b1, 8'h22);
        chk("idle_err_pulse", 32'(frame_err), 32'd1);
        idle(1);
        chk("idle_err_width", 32'(frame_err), 32'd0);
        idle(3);
        chk("idle_drop", 32'(outq.size() - qb), 32'd0);
        chk("idle_err_cnt", 32'(errs - eb), 32'd1);

        // Exponent after 10 samples truncates frame and restarts count
        do_reset();
        qb = outq.size(); eb = errs;
        drive(1'b1, 4'd0, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 4'd0, 1'b1, 8'd1);
        drive(1'b1, 4'd0, 1'b0, 8'd0);
        for (int i = 0; i < 64; i++) drive(1'b0, 4'd0, 1'b1, 8'd1);
        idle(4);
        n = outq.size() - qb;
        chk("trunc_err", 32'(errs - eb), 32'd1);
        chk("trunc_count", 32'(n), 32'd74);
        for (int k = 0; k < n && k < 74; k++)
            chk($sformatf("trunc_l%0d", k), 32'(outq[qb+k].l),
                32'(k == 73));

        // exp_in wiggles mid-frame without exp_valid
        do_reset();
        qb = outq.size();
        drive(1'b1, 4'd2, 1'b1, 8'd1);
        drive(1'b0, 4'd7, 1'b1, 8'd1);
        drive(1'b0, 4'd9, 1'b1, 8'd1);
        drive(1'b0, 4'd15, 1'b1, 8'd1);
        idle(3);
        n = outq.size() - qb;
        chk("hold_count", 32'(n), 32'd4);
        for (int k = 0; k < n && k < 4; k++)
            chk($sformatf("hold_d%0d", k), 32'(outq[qb+k].d), 32'h0004);

        // Asynchronous reset with samples in flight
        do_reset();
        drive(1'b1, 4'd3, 1'b1, 8'h40);
        drive(1'b0, 4'd3, 1'b1, 8'h40);
        chk("rst_pre_valid", 32'(dout_valid), 32'd1);
        chk("rst_pre_dout", 32'(dout), 32'h0200);
        exp_valid = 1'b0;
        din_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_dout", 32'(dout), 32'h0);
        chk("rst_async_flags",
            {28'd0, dout_valid, dout_last, dout_sat, frame_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qb = outq.size(); eb = errs;
        drive(1'b0, 4'd0, 1'b1, 8'h11);
        idle(4);
        chk("rst_after_err", 32'(errs - eb), 32'd1);
        chk("rst_after_drop", 32'(outq.size() - qb), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfp_unpack.md
# bfp_unpack

Block-floating-point decoder for the DoA fixed-point datapath. It accepts frames of FRAME_LEN signed mantissas that share one unsigned exponent, and reconstructs each sample as mantissa·2^exp in a wider signed fixed-point format, with saturation. It is the receive-side counterpart of the narrowing casts and block scalers upstream, and restores full dynamic range before correlation/accumulation stages.

## Interface
- DIN_WIDTH, 8, mantissa width (signed)
- DIN_POINT, 7, mantissa fractional bits
- DOUT_WIDTH, 16, output width (signed)
- DOUT_POINT, 7, output fractional bits; must satisfy DOUT_POINT ≥ DIN_POINT and DOUT_WIDTH−DOUT_POINT ≥ DIN_WIDTH−DIN_POINT
- EXP_WIDTH, 4, unsigned exponent width (shift 0..2^EXP_WIDTH−1)
- FRAME_LEN, 64, mantissas per frame (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- exp_in  in  EXP_WIDTH  shared exponent for the next frame
- exp_valid  in  1  exp_in qualifier; marks frame start
- din  in  DIN_WIDTH  mantissa sample
- din_valid  in  1  din qualifier
- dout  out  DOUT_WIDTH  reconstructed sample
- dout_valid  out  1  dout qualifier
- dout_last  out  1  high with last sample of a frame
- dout_sat  out  1  high with a sample that saturated
- frame_err  out  1  one-cycle error pulse

## Operation
- States: IDLE (waiting for exponent), RUN (accepting samples).
- IDLE: exp_valid=1 → latch exp_in, sample count=0, go RUN. din_valid=1 in IDLE without exp_valid → sample dropped, frame_err pulse. exp_valid and din_valid together in IDLE → exponent latched, din is the first sample of the frame (count→1).
- RUN: each din_valid increments count; the sample with count=FRAME_LEN−1 is flagged last, then state → IDLE. exp_valid in RUN (frame incomplete) → frame_err pulse, new exponent latched, count restarts at 0 (or 1 if din_valid same cycle, that din belongs to new frame); previous frame is truncated, no dout_last issued for it.
- FRAME_LEN=1: every sample is last; state returns to IDLE each sample.
- Arithmetic: align mantissa by appending DOUT_POINT−DIN_POINT zero LSBs, sign-extend to DOUT_WIDTH+2^EXP_WIDTH−1 bits, shift left by exp. If bits above DOUT_WIDTH−1 are not all equal to the sign → saturate: positive → 0x7F..F, negative → 0x80..0, dout_sat=1. Otherwise dout = low DOUT_WIDTH bits, dout_sat=0. Most-negative output value is representable and does not flag saturation.
- Exponent applied to a sample is the one latched for its frame, even if exp_in changes mid-frame without exp_valid.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, count=0, latched exp=0, dout=0, dout_valid=0, dout_last=0, dout_sat=0, frame_err=0.
- Latency din→dout: 2 cycles (stage 1: align + exponent/last registered; stage 2: shift + saturate). dout_last, dout_sat aligned with dout_valid.
- frame_err: asserted 1 cycle after the offending input cycle, width exactly 1 cycle per event.
- Throughput: 1 sample/cycle, back-to-back frames allowed (exp_valid in same cycle as the next frame's first din after a last sample).
- No backpressure; dout_valid is the registered din_valid of accepted samples only (dropped samples produce no output).
- Reset mid-frame: in-flight pipeline samples discarded, outputs cleared immediately.

## Test plan
- Basic: exp_valid with exp=3, din=0x40 → 2 cycles later dout=0x0200, dout_valid=1, dout_sat=0.
- Saturation: exp=9, din=0x7F → dout=0x7FFF, dout_sat=1; exp=9, din=0x80 → dout=0x8000, dout_sat=1; exp=8, din=0x80 → dout=0x8000, dout_sat=0; exp=8, din=0x7F → dout=0x7F00, dout_sat=0.
- Framing: exp then 64 consecutive samples → dout_last only on 64th output; next exp_valid same cycle as sample 65 → seamless new frame, no frame_err.
- Errors: din_valid in IDLE without exp → no dout_valid, one frame_err pulse; exp_valid after 10 samples of a frame → frame_err pulse, count restarts, dout_last appears after 64 further samples.
- Exponent stability: exp_in changes mid-frame with exp_valid=0 → outputs keep latched exponent.
- Reset: assert rst_n=0 mid-frame with samples in pipeline → all outputs 0 asynchronously; after release, din without exp gives frame_err.
